irq_tick_gen: RTL and testbench

Parametrised multi-channel periodic interrupt generator for the zycap demo region. Each channel owns a programmable-period tick counter that raises a sticky pending bit. A maskable, registered aggregate `irq` plus the index of the lowest active channel are presented to the interrupt controller. Each channel reports overrun when a tick arrives before software acknowledges the previous one.

---
 rtl/irq_tick_gen.sv | 84 ++++++++
 tb/tb_irq_tick_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_tick_gen.sv
// Multi-channel periodic interrupt generator: per-channel tick counters set sticky
// pending/overrun flags; a registered, maskable aggregate irq and lowest-index id follow.
module irq_tick_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  localparam int unsigned IDW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS-1:0]       mask,
  input  logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      irq,
  output logic [IDW-1:0]            irq_id
);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] tick_c;
  logic [CHANNELS-1:0] pending_nxt_c;
  logic [CHANNELS-1:0] overrun_nxt_c;
  logic [CHANNELS-1:0] active_c;
  logic                irq_nxt_c;
  logic [IDW-1:0]      id_nxt_c;

  // Tick on >= so a period lowered below the running count fires immediately.
  always_comb begin
    tick_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      tick_c[i] = enable[i] && (cnt[i] >= period[i*WIDTH +: WIDTH]);
    end
  end

  // A tick beats a same-cycle ack; the ack still consumes any prior overrun.
  always_comb begin
    pending_nxt_c = tick_c | (pending & ~ack);
    overrun_nxt_c = (tick_c & pending & ~ack) | (overrun & ~ack);
  end

  // Lowest-index unmasked pending channel wins.
  always_comb begin
    active_c  = pending & ~mask;
    irq_nxt_c = |active_c;
    id_nxt_c  = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (active_c[i]) begin
        id_nxt_c = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (!enable[i] || tick_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      irq     <= 1'b0;
      irq_id  <= '0;
    end else begin
      pending <= pending_nxt_c;
      overrun <= overrun_nxt_c;
      irq     <= irq_nxt_c;
      irq_id  <= id_nxt_c;
    end
  end

endmodule

// File: tb/tb_irq_tick_gen.sv
// Directed plus randomized bench for irq_tick_gen, checked against a cycle-level
// behavioural model of tick/pending/overrun/irq rules.
module tb_irq_tick_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] enable = '0;
  logic [CH*W-1:0] period = '0;
  logic [CH-1:0] mask = '0;
  logic [CH-1:0] ack = '0;
  logic [CH-1:0] pending;
  logic [CH-1:0] overrun;
  logic          irq;
  logic [1:0]    irq_id;

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_cnt [CH];
  bit m_pend [CH];
  bit m_over [CH];
  bit m_irq;
  int m_id;

  irq_tick_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .mask(mask), .ack(ack), .pending(pending), .overrun(overrun),
    .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_pend[i] = 0; m_over[i] = 0;
    end
    m_irq = 0; m_id = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int p;
    bit t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_irq = 0; m_id = 0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (m_pend[i] && !mask[i]) begin
        m_irq = 1; m_id = i;
      end
    end
    for (int i = 0; i < CH; i++) begin
      p = int'(period[i*W +: W]);
      t = enable[i] && (m_cnt[i] >= p);
      if (!enable[i] || t) m_cnt[i] = 0;
      else m_cnt[i] = m_cnt[i] + 1;
      if (t && m_pend[i] && !ack[i]) m_over[i] = 1;
      else if (ack[i]) m_over[i] = 0;
      if (t) m_pend[i] = 1;
      else if (ack[i]) m_pend[i] = 0;
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] ep, eo;
    for (int i = 0; i < CH; i++) begin
      ep[i] = m_pend[i]; eo[i] = m_over[i];
    end
    check("pending", 32'(pending), 32'(ep));
    check("overrun", 32'(overrun), 32'(eo));
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_id", 32'(irq_id), 32'(m_id));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_p(input int ch, input int val);
    period[ch*W +: W] = W'(val);
  endtask

  initial begin
    model_reset();
    // Async reset with all channels enabled
    #2;
    rst_n = 1'b0;
    enable = '1;
    period = {CH{16'd1}};
    #1;
    check("reset_pending", 32'(pending), 0);
    check("reset_irq", 32'(irq), 0);
    cycles(3);
    // Release with channels disabled: idle for 20 cycles
    enable = '0;
    rst_n = 1'b1;
    cycles(20);
    check("idle_irq", 32'(irq), 0);

    // Basic tick: ch0 P=3
    set_p(0, 3);
    enable = 4'b0001;
    cycles(3);
    check("basic_pend_before", 32'(pending[0]), 0);
    cycle();
    check("basic_pend_E3", 32'(pending[0]), 1);
    check("basic_irq_E3", 32'(irq), 0);
    cycle();
    check("basic_irq_E4", 32'(irq), 1);
    check("basic_id_E4", 32'(irq_id), 0);
    cycle();
    ack = 4'b0001;
    cycle();
    ack = '0;
    check("basic_ack_pend", 32'(pending[0]), 0);
    cycle();
    check("basic_ack_irq", 32'(irq), 0);
    enable = '0;
    ack = 4'b0001;
    cycle();
    ack = '0;
    cycles(2);

    // Overrun and ack race: ch1 P=2
    set_p(1, 2);
    enable = 4'b0010;
    cycles(6);
    check("ovr_set", 32'(overrun[1]), 1);
    cycles(2);
    ack = 4'b0010;
    cycle();
    ack = '0;
    check("race_pend", 32'(pending[1]), 1);
    check("race_ovr", 32'(overrun[1]), 0);

    // Priority and mask with ch1 and ch3 pending
    set_p(3, 5);
    enable = 4'b1010;
    cycles(8);
    check("prio_id", 32'(irq_id), 1);
    mask = 4'b0010;
    cycle();
    check("mask_id", 32'(irq_id), 3);
    mask = 4'b1010;
    cycle();
    check("mask_irq", 32'(irq), 0);
    check("mask_id0", 32'(irq_id), 0);
    check("mask_pend", 32'(pending & 4'b1010), 32'(4'b1010));

    // Live period change on ch2
    enable = '0;
    mask = '0;
    ack = '1;
    cycle();
    ack = '0;
    set_p(2, 100);
    enable = 4'b0100;
    cycles(50);
    check("live_no_tick", 32'(pending[2]), 0);
    set_p(2, 10);
    cycle();
    check("live_tick", 32'(pending[2]), 1);
    ack = 4'b0100;
    cycle();
    ack = '0;
    cycles(9);
    check("live_wait", 32'(pending[2]), 0);
    cycle();
    check("live_period11", 32'(pending[2]), 1);

    // P=0 ticks every enabled cycle
    enable = '0;
    ack = '1;
    cycle();
    ack = '0;
    set_p(0, 0);
    enable = 4'b0001;
    cycle();
    check("p0_pend", 32'(pending[0]), 1);
    check("p0_ovr1", 32'(overrun[0]), 0);
    cycle();
    check("p0_ovr2", 32'(overrun[0]), 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) enable = 4'($urandom);
      if ($urandom_range(0, 19) == 0) set_p($urandom_range(0, CH - 1), $urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      cycle();
    end
    ack = '0;

    // Async reset mid-run between edges
    enable = '1;
    period = {16'd3, 16'd0, 16'd1, 16'd0};
    cycles(4);
    check("pre_reset_irq", 32'(irq), 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_reset_pending", 32'(pending), 0);
    check("mid_reset_overrun", 32'(overrun), 0);
    check("mid_reset_irq", 32'(irq), 0);
    check("mid_reset_id", 32'(irq_id), 0);
    cycle();
    rst_n = 1'b1;
    enable = 4'b1000;
    cycles(3);
    check("restart_no_tick", 32'(pending[3]), 0);
    cycle();
    check("restart_tick", 32'(pending[3]), 1);
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
